bus_datapath: RTL and testbench
===============================

Name: bus_datapath

Overview:
- Register/bus datapath of the mini computer. It responds to the enable, set, op and b1 strobes that the control section produces.
- Contains the shared 8-bit bus, IAR, IR, MAR, TMP, ACC, R0–R3, flags, a 256x8 RAM and the ALU.
- Returns the IR to the control section.
- A side-band load port lets a bench or boot loader write the RAM before a program runs.

Parameters:
- DATA_W, 8, width of the bus and every register. The RAM address is also DATA_W bits.
- RAM_DEPTH, 256, number of RAM words. Must equal 2**DATA_W.

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  asynchronous reset, active-low
- ram_en, acc_en, r0_en, r1_en, r2_en, r3_en, iar_en  in  1 each  bus source enables
- ir_set, mar_set, acc_set, ram_set, tmp_set, r0_set, r1_set, r2_set, r3_set, iar_set  in  1 each  capture strobes
- b1  in  1  replaces the ALU B operand with 0x01
- op  in  3  ALU operation
- load_en  in  1  side-band RAM write strobe
- load_addr  in  DATA_W  side-band write address
- load_data  in  DATA_W  side-band write data
- ir  out  DATA_W  instruction register, to the control section
- bus  out  DATA_W  current bus value (observation)
- acc  out  DATA_W  accumulator
- flags  out  4  {carry, a_larger, equal, zero}

Behaviour:
- Reset (rst=0, asynchronous, any time including mid-instruction):
  - IAR, IR, MAR, TMP, ACC, R0–R3 and flags go to 0 immediately.
  - RAM contents are not reset.
  - The load port is ignored while in reset.
- Bus (combinational):
  - bus = bitwise OR of all enabled sources (wired-OR).
  - With no enable asserted, bus = 0x00.
  - The ram_en source is RAM[MAR].
- Set strobes:
  - Sampled at the rising edge. Each asserted strobe loads the current bus into its register.
  - Several strobes asserted together all load the same value.
  - A register both enabled and set keeps its value.
  - Strobes are level-sampled. A strobe held N cycles reloads the register N times.
- RAM write:
  - ram_set writes the bus to RAM[MAR] at the edge.
  - load_en writes load_data to RAM[load_addr] at the edge.
  - If both are asserted in the same cycle, load_en wins and that ram_set is dropped.
  - A read of the same address in the same cycle returns the old data. The new data is visible the cycle after the write.
- ALU (combinational):
  - A = bus; B = b1 ? 0x01 : TMP.
  - op 000 ADD: result = A+B mod 256; carry = bit 8.
  - op 001 SHR: result = A>>1; carry = A[0].
  - op 010 SHL: result = A<<1; carry = A[7].
  - op 011 NOT: result = ~A.
  - op 100 AND, 101 OR, 110 XOR: bitwise A op B.
  - op 111 CMP: result = A.
  - For NOT, AND, OR, XOR and CMP, carry = 0.
  - a_larger = (A > B, unsigned); equal = (A == B). Both are computed for every op.
  - zero = (result == 0).
- ACC and flags:
  - On acc_set, ACC captures the ALU result, not the raw bus, and flags capture {carry, a_larger, equal, zero} at the same edge.
  - Flags change only on acc_set.
- Latency:
  - Any register write is visible on bus/outputs one cycle after its set edge.
  - Register-to-register transfer takes 1 cycle: en and set in the same cycle.
- Fetch-increment sequence:
  - Cycle 1: iar_en, b1, op=000, acc_set, mar_set. This gives MAR=IAR and ACC=IAR+1.
  - Cycle 2: ram_en, ir_set. This gives IR=RAM[MAR].
  - Cycle 3: acc_en, iar_set. This gives IAR=ACC.
- Wrap-around:
  - IAR increment from 0xFF gives 0x00 with carry=1.
  - MAR and load_addr cover all 256 addresses with no aliasing.

Test Plan:
- Reset mid-op: load R1=0x5A via RAM, then drop rst while acc_set is high. Required: ir, acc, flags and bus all 0 within the reset. After release, RAM[0x00] still holds its preloaded byte.
- Fetch/increment: preload RAM[0x00]=0x81 via load port, then run the 3-cycle fetch sequence from reset. Required: IR=0x81, IAR=0x01, ACC=0x01, flags=0000.
- ADD with carry: R1=0xF0 and R2=0x20 loaded from RAM. Then r2_en+tmp_set, then r1_en+op=000+acc_set. Required: acc=0x10, carry=1, a_larger=1, equal=0, zero=0.
- CMP/shift:
  - TMP=0x33, bus=R0=0x33, op=111, acc_set. Required: acc=0x33, equal=1, a_larger=0, zero=0.
  - Then bus=R0=0x80, op=010, acc_set. Required: acc=0x00, carry=1, zero=1, equal=0, a_larger=1.
- Wired-OR and multi-set: R0=0x0F and R1=0xF0. Assert r0_en+r1_en with r2_set+r3_set. Required: bus=0xFF, R2=R3=0xFF.
- RAM write collision: MAR=0x10 and R3=0xAA. Assert r3_en+ram_set together with load_en (addr 0x10, data 0x55). Required: RAM[0x10]=0x55. A ram_set to MAR=0xFF with no load_en then reads back 0xAA on the next ram_en.

Source files
------------

// File: rtl/bus_datapath.sv
// Mini-computer register/bus datapath: wired-OR bus, IAR/IR/MAR/TMP/ACC/R0-R3,
// flags, 256x8 RAM with a side-band load port, and the combinational ALU.
module bus_datapath #(
  parameter int DATA_W    = 8,
  parameter int RAM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ram_en,
  input  logic              acc_en,
  input  logic              r0_en,
  input  logic              r1_en,
  input  logic              r2_en,
  input  logic              r3_en,
  input  logic              iar_en,
  input  logic              ir_set,
  input  logic              mar_set,
  input  logic              acc_set,
  input  logic              ram_set,
  input  logic              tmp_set,
  input  logic              r0_set,
  input  logic              r1_set,
  input  logic              r2_set,
  input  logic              r3_set,
  input  logic              iar_set,
  input  logic              b1,
  input  logic [2:0]        op,
  input  logic              load_en,
  input  logic [DATA_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] bus,
  output logic [DATA_W-1:0] acc,
  output logic [3:0]        flags
);

  logic [DATA_W-1:0] r_iar, r_ir, r_mar, r_tmp, r_acc;
  logic [DATA_W-1:0] r_r0, r_r1, r_r2, r_r3;
  logic [3:0]        r_flags;
  logic [DATA_W-1:0] r_ram [0:RAM_DEPTH-1];

  logic [DATA_W-1:0] w_bus, w_ram_rd, w_b, w_res;
  logic [DATA_W:0]   w_sum;
  logic              w_carry, w_a_larger, w_equal, w_zero;

  assign w_ram_rd = r_ram[r_mar];

  // Wired-OR of every enabled source; idle bus reads as zero.
  assign w_bus = ({DATA_W{ram_en}} & w_ram_rd) |
                 ({DATA_W{acc_en}} & r_acc)    |
                 ({DATA_W{r0_en}}  & r_r0)     |
                 ({DATA_W{r1_en}}  & r_r1)     |
                 ({DATA_W{r2_en}}  & r_r2)     |
                 ({DATA_W{r3_en}}  & r_r3)     |
                 ({DATA_W{iar_en}} & r_iar);

  always_comb begin
    w_b     = b1 ? DATA_W'(1) : r_tmp;
    w_sum   = {1'b0, w_bus} + {1'b0, w_b};
    w_res   = w_bus;
    w_carry = 1'b0;
    case (op)
      3'b000: begin
        w_res   = w_sum[DATA_W-1:0];
        w_carry = w_sum[DATA_W];
      end
      3'b001: begin
        w_res   = w_bus >> 1;
        w_carry = w_bus[0];
      end
      3'b010: begin
        w_res   = w_bus << 1;
        w_carry = w_bus[DATA_W-1];
      end
      3'b011:  w_res = ~w_bus;
      3'b100:  w_res = w_bus & w_b;
      3'b101:  w_res = w_bus | w_b;
      3'b110:  w_res = w_bus ^ w_b;
      default: w_res = w_bus;
    endcase
    w_a_larger = (w_bus > w_b);
    w_equal    = (w_bus == w_b);
    w_zero     = (w_res == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_iar   <= '0;
      r_ir    <= '0;
      r_mar   <= '0;
      r_tmp   <= '0;
      r_acc   <= '0;
      r_r0    <= '0;
      r_r1    <= '0;
      r_r2    <= '0;
      r_r3    <= '0;
      r_flags <= '0;
    end else begin
      if (iar_set) r_iar <= w_bus;
      if (ir_set)  r_ir  <= w_bus;
      if (mar_set) r_mar <= w_bus;
      if (tmp_set) r_tmp <= w_bus;
      if (r0_set)  r_r0  <= w_bus;
      if (r1_set)  r_r1  <= w_bus;
      if (r2_set)  r_r2  <= w_bus;
      if (r3_set)  r_r3  <= w_bus;
      if (acc_set) begin
        r_acc   <= w_res;
        r_flags <= {w_carry, w_a_larger, w_equal, w_zero};
      end
    end
  end

  // RAM keeps its contents through reset; the load port overrides a same-cycle ram_set.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (load_en)      r_ram[load_addr] <= load_data;
      else if (ram_set) r_ram[r_mar]     <= w_bus;
    end
  end

  assign ir    = r_ir;
  assign bus   = w_bus;
  assign acc   = r_acc;
  assign flags = r_flags;

endmodule

// File: tb/tb_bus_datapath.sv
// Directed bench for bus_datapath: reset, fetch/increment, ALU ops and flags,
// wired-OR multi-set, RAM write collision and read-during-write.
module tb_bus_datapath;

  logic       clk = 1'b0;
  logic       rst;
  logic       ram_en, acc_en, r0_en, r1_en, r2_en, r3_en, iar_en;
  logic       ir_set, mar_set, acc_set, ram_set, tmp_set;
  logic       r0_set, r1_set, r2_set, r3_set, iar_set;
  logic       b1;
  logic [2:0] op;
  logic       load_en;
  logic [7:0] load_addr, load_data;
  logic [7:0] ir, bus, acc;
  logic [3:0] flags;

  int n_tests = 0;
  int n_fail  = 0;

  logic [2:0] t_op    [6];
  logic [7:0] t_acc   [6];
  logic [3:0] t_flags [6];

  bus_datapath #(.DATA_W(8), .RAM_DEPTH(256)) dut (
    .clk(clk), .rst(rst),
    .ram_en(ram_en), .acc_en(acc_en), .r0_en(r0_en), .r1_en(r1_en),
    .r2_en(r2_en), .r3_en(r3_en), .iar_en(iar_en),
    .ir_set(ir_set), .mar_set(mar_set), .acc_set(acc_set), .ram_set(ram_set),
    .tmp_set(tmp_set), .r0_set(r0_set), .r1_set(r1_set), .r2_set(r2_set),
    .r3_set(r3_set), .iar_set(iar_set),
    .b1(b1), .op(op),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .ir(ir), .bus(bus), .acc(acc), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ram_en = 0; acc_en = 0; r0_en = 0; r1_en = 0; r2_en = 0; r3_en = 0; iar_en = 0;
    ir_set = 0; mar_set = 0; acc_set = 0; ram_set = 0; tmp_set = 0;
    r0_set = 0; r1_set = 0; r2_set = 0; r3_set = 0; iar_set = 0;
    b1 = 0; op = 3'b000; load_en = 0; load_addr = 8'h00; load_data = 8'h00;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic loadp(input logic [7:0] a, input logic [7:0] d);
    load_en = 1; load_addr = a; load_data = d;
    step();
    idle();
  endtask

  initial begin
    t_op[0] = 3'b000; t_acc[0] = 8'hE1; t_flags[0] = 4'b0100;
    t_op[1] = 3'b001; t_acc[1] = 8'h52; t_flags[1] = 4'b1100;
    t_op[2] = 3'b011; t_acc[2] = 8'h5A; t_flags[2] = 4'b0100;
    t_op[3] = 3'b100; t_acc[3] = 8'h24; t_flags[3] = 4'b0100;
    t_op[4] = 3'b101; t_acc[4] = 8'hBD; t_flags[4] = 4'b0100;
    t_op[5] = 3'b110; t_acc[5] = 8'h99; t_flags[5] = 4'b0100;

    // Reset state
    idle();
    rst = 1;
    #2 rst = 0;
    #1;
    chk("rst_ir", ir, 8'h00);
    chk("rst_acc", acc, 8'h00);
    chk("rst_flags", {4'h0, flags}, 8'h00);
    iar_en = 1; #1;
    chk("rst_iar", bus, 8'h00);
    idle();
    step(); step();
    rst = 1;

    // Fetch/increment
    loadp(8'h00, 8'h81);
    iar_en = 1; b1 = 1; op = 3'b000; acc_set = 1; mar_set = 1;
    step(); idle();
    chk("fetch1_acc", acc, 8'h01);
    ram_en = 1; ir_set = 1;
    step(); idle();
    chk("fetch2_ir", ir, 8'h81);
    acc_en = 1; iar_set = 1;
    step(); idle();
    chk("fetch_ir", ir, 8'h81);
    chk("fetch_acc", acc, 8'h01);
    chk("fetch_flags", {4'h0, flags}, 8'h00);
    iar_en = 1; #1;
    chk("fetch_iar", bus, 8'h01);
    idle();

    // Reset mid-op, load port ignored during reset, RAM retained
    loadp(8'h00, 8'h5A);
    ram_en = 1; r1_set = 1;
    step(); idle();
    r1_en = 1; #1;
    chk("r1_load", bus, 8'h5A);
    op = 3'b000; acc_set = 1; load_en = 1; load_addr = 8'h00; load_data = 8'hEE;
    #2 rst = 0;
    #1;
    chk("midrst_ir", ir, 8'h00);
    chk("midrst_acc", acc, 8'h00);
    chk("midrst_flags", {4'h0, flags}, 8'h00);
    chk("midrst_bus", bus, 8'h00);
    step();
    chk("midrst_acc_edge", acc, 8'h00);
    idle();
    rst = 1;
    ram_en = 1; #1;
    chk("ram_kept", bus, 8'h5A);
    idle();

    // ADD with carry
    loadp(8'h00, 8'hF0);
    ram_en = 1; r1_set = 1; step(); idle();
    loadp(8'h00, 8'h20);
    ram_en = 1; r2_set = 1; step(); idle();
    r2_en = 1; tmp_set = 1; step(); idle();
    r1_en = 1; op = 3'b000; acc_set = 1; step(); idle();
    chk("add_acc", acc, 8'h10);
    chk("add_flags", {4'h0, flags}, 8'h0C);

    // CMP then SHL
    loadp(8'h00, 8'h33);
    ram_en = 1; r0_set = 1; tmp_set = 1; step(); idle();
    r0_en = 1; op = 3'b111; acc_set = 1; step(); idle();
    chk("cmp_acc", acc, 8'h33);
    chk("cmp_flags", {4'h0, flags}, 8'h02);
    loadp(8'h00, 8'h80);
    ram_en = 1; r0_set = 1; step(); idle();
    r0_en = 1; op = 3'b010; acc_set = 1; step(); idle();
    chk("shl_acc", acc, 8'h00);
    chk("shl_flags", {4'h0, flags}, 8'h0D);
    r0_en = 1; op = 3'b011; step(); idle();
    chk("hold_acc", acc, 8'h00);
    chk("hold_flags", {4'h0, flags}, 8'h0D);

    // Remaining ALU ops with TMP=0x3C, A=R0=0xA5
    loadp(8'h00, 8'h3C);
    ram_en = 1; tmp_set = 1; step(); idle();
    loadp(8'h00, 8'hA5);
    ram_en = 1; r0_set = 1; step(); idle();
    for (int i = 0; i < 6; i++) begin
      r0_en = 1; op = t_op[i]; acc_set = 1; step(); idle();
      chk($sformatf("alu%0d_acc", i), acc, t_acc[i]);
      chk($sformatf("alu%0d_flags", i), {4'h0, flags}, {4'h0, t_flags[i]});
    end

    // Wired-OR with multiple set strobes
    loadp(8'h00, 8'h0F);
    ram_en = 1; r0_set = 1; step(); idle();
    loadp(8'h00, 8'hF0);
    ram_en = 1; r1_set = 1; step(); idle();
    r0_en = 1; r1_en = 1; r2_set = 1; r3_set = 1; #1;
    chk("wor_bus", bus, 8'hFF);
    step(); idle();
    r2_en = 1; #1;
    chk("wor_r2", bus, 8'hFF);
    r2_en = 0; r3_en = 1; #1;
    chk("wor_r3", bus, 8'hFF);
    idle();

    // RAM write collision and read-during-write
    loadp(8'h00, 8'h10);
    ram_en = 1; mar_set = 1; step(); idle();
    loadp(8'h10, 8'hAA);
    ram_en = 1; r3_set = 1; step(); idle();
    r3_en = 1; ram_set = 1; load_en = 1; load_addr = 8'h10; load_data = 8'h55;
    step(); idle();
    ram_en = 1; #1;
    chk("collide_ram", bus, 8'h55);
    load_en = 1; load_addr = 8'h10; load_data = 8'h77; #1;
    chk("rdw_old", bus, 8'h55);
    step();
    load_en = 0; #1;
    chk("rdw_new", bus, 8'h77);
    idle();
    loadp(8'h10, 8'hFF);
    ram_en = 1; mar_set = 1; step(); idle();
    r3_en = 1; ram_set = 1; step(); idle();
    ram_en = 1; #1;
    chk("ram_ff", bus, 8'hAA);
    idle();

    // IAR wrap from 0xFF
    loadp(8'hFF, 8'hFF);
    ram_en = 1; iar_set = 1; step(); idle();
    iar_en = 1; b1 = 1; op = 3'b000; acc_set = 1; mar_set = 1; step(); idle();
    chk("wrap_acc", acc, 8'h00);
    chk("wrap_flags", {4'h0, flags}, 8'h0D);
    acc_en = 1; iar_set = 1; step(); idle();
    iar_en = 1; #1;
    chk("wrap_iar", bus, 8'h00);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
